// File: rtl/fpga_conn_box_pkg.sv
// fpga_conn_box_pkg: shared constants for the routing connection box.
// Holds the default track count, the configuration-width derivation and
// the bit positions of the enable and direction fields inside cfg.
package fpga_conn_box_pkg;

  // Default number of routing tracks a box connects to.
  localparam int DEFAULT_N_TRACKS = 4;

  // Direction field always starts at bit 0 of cfg.
  localparam int DIR_LSB = 0;

  // Enable field sits directly above the direction field.
  localparam int EN_LSB = DEFAULT_N_TRACKS;

  // Two configuration bits per track: one enable, one direction.
  function automatic int cfg_width(input int n_tracks);
    return 2 * n_tracks;
  endfunction

  // Enable-field LSB for a non-default track count.
  function automatic int en_lsb(input int n_tracks);
    return n_tracks;
  endfunction

endpackage

// File: rtl/fpga_conn_box_sw.sv
// fpga_conn_box_sw: one track's direction-controlled switch.
// When closed with dir=1 it requests to drive the pin with the track value;
// when closed with dir=0 it drives the track with the pin value.
// The actual tri-state buffers live in the top so that a single resolved
// driver exists per net.
module fpga_conn_box_sw (
  input  logic en_i,     // switch closed
  input  logic dir_i,    // 1: track -> pin, 0: pin -> track
  input  logic a_i,      // current value of this track
  input  logic b_i,      // resolved value of the pin net
  output logic a_oe_o,   // drive enable for the track
  output logic a_o,      // value to put on the track
  output logic b_req_o,  // request to drive the pin
  output logic b_o       // value offered to the pin
);

  // Pin-to-track path: only active when closed and pointing at the track.
  assign a_oe_o  = en_i & ~dir_i;
  assign a_o     = b_i;

  // Track-to-pin path: offer the track value; the top picks one requester.
  assign b_req_o = en_i & dir_i;
  assign b_o     = a_i;

endmodule

// File: rtl/fpga_conn_box.sv
// fpga_conn_box: FPGA routing connection box joining pin b to tracks a.
// The configuration is a serial shift register on the scan chain si -> so;
// the routing path itself is purely combinational.
// Optional build macro: FPGA_CONN_BOX_SO_RETIME_EN -- when defined, so is
// re-registered on the falling clock edge for extra hold margin on the chain.
module fpga_conn_box
  import fpga_conn_box_pkg::*;
#(
  parameter int N_TRACKS = DEFAULT_N_TRACKS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                si,
  output logic                so,
  inout  wire  [N_TRACKS-1:0] a,
  inout  wire                 b
);

  localparam int CFG_W = cfg_width(N_TRACKS);
  localparam int EN_LO = en_lsb(N_TRACKS);

  logic [CFG_W-1:0]    cfg_q;
  logic [CFG_W-1:0]    cfg_d;
  logic [N_TRACKS-1:0] en;
  logic [N_TRACKS-1:0] dir;
  logic [N_TRACKS-1:0] a_oe;
  logic [N_TRACKS-1:0] a_out;
  logic [N_TRACKS-1:0] b_req;
  logic [N_TRACKS-1:0] b_val;
  logic                b_drv_en;
  logic                b_drv_val;

  // Shift one bit in at the LSB on every edge; first bit ends up at the MSB.
  always_comb begin
    cfg_d = {cfg_q[CFG_W-2:0], si};
  end

  // Configuration register; reset discards any partially shifted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign en  = cfg_q[EN_LO   +: N_TRACKS];
  assign dir = cfg_q[DIR_LSB +: N_TRACKS];

`ifdef FPGA_CONN_BOX_SO_RETIME_EN
  logic so_q;

  // Falling-edge copy of the chain MSB gives the next box half a cycle of hold.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_q <= 1'b0;
    end else begin
      so_q <= cfg_q[CFG_W-1];
    end
  end

  assign so = so_q;
`else
  assign so = cfg_q[CFG_W-1];
`endif

  // One switch per track plus its track-side tri-state buffer.
  for (genvar gi = 0; gi < N_TRACKS; gi++) begin : g_track
    fpga_conn_box_sw u_sw (
      .en_i    (en[gi]),
      .dir_i   (dir[gi]),
      .a_i     (a[gi]),
      .b_i     (b),
      .a_oe_o  (a_oe[gi]),
      .a_o     (a_out[gi]),
      .b_req_o (b_req[gi]),
      .b_o     (b_val[gi])
    );

    assign a[gi] = a_oe[gi] ? a_out[gi] : 1'bz;
  end

  // Lowest-index requesting track wins the pin; scanning downward lets the
  // lowest index overwrite higher ones, so only one driver ever reaches b.
  always_comb begin
    b_drv_en  = 1'b0;
    b_drv_val = 1'b0;
    for (int i = N_TRACKS - 1; i >= 0; i--) begin
      if (b_req[i]) begin
        b_drv_en  = 1'b1;
        b_drv_val = b_val[i];
      end
    end
  end

  assign b = b_drv_en ? b_drv_val : 1'bz;

endmodule

// File: tb/tb_fpga_conn_box.sv
// tb_fpga_conn_box: directed test of the connection box.
// Tracks and pin carry pull-ups, so a net nobody drives reads as 1; the
// bench arranges for every released-net check to have a 0 source nearby so
// an unwanted DUT driver shows up as a 0.
module tb_fpga_conn_box;

  logic       clk;
  logic       rst_n;
  logic       si;
  logic       so;
  wire  [3:0] a;
  wire        b;

  logic [3:0] a_drv;
  logic [3:0] a_oe;
  logic       b_drv;
  logic       b_oe;

  int n_checks;
  int n_fail;

  for (genvar gi = 0; gi < 4; gi++) begin : g_tb_track
    assign a[gi] = a_oe[gi] ? a_drv[gi] : 1'bz;
    pullup (a[gi]);
  end
  assign b = b_oe ? b_drv : 1'bz;
  pullup (b);

  fpga_conn_box #(.N_TRACKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .si    (si),
    .so    (so),
    .a     (a),
    .b     (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One shift edge; returns just after the following falling edge.
  task automatic shift_bit(input logic v);
    si = v;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic release_all();
    a_oe = 4'b0000;
    b_oe = 1'b0;
  endtask

  logic [6:0] chain_exp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    si       = 1'b0;
    a_drv    = 4'b0000;
    a_oe     = 4'b0000;
    b_drv    = 1'b0;
    b_oe     = 1'b0;

    // Reset held while si toggles: nothing may shift in.
    for (int i = 0; i < 4; i++) shift_bit(i[0]);
    check_eq("reset_so", {7'd0, so}, 8'h00);
    check_eq("reset_a_released", {4'd0, a}, 8'h0F);
    check_eq("reset_b_released", {7'd0, b}, 8'h01);
    // Drive tracks low: a closed switch would pull b low.
    a_drv = 4'b0000; a_oe = 4'b1111; #1;
    check_eq("reset_b_open", {7'd0, b}, 8'h01);
    release_all();

    rst_n = 1'b1;
    load_cfg(8'h00);
    check_eq("zeros_so", {7'd0, so}, 8'h00);
    a_drv = 4'b0000; a_oe = 4'b1111; #1;
    check_eq("zeros_b_open", {7'd0, b}, 8'h01);
    release_all();
    b_drv = 1'b0; b_oe = 1'b1; #1;
    check_eq("zeros_a_open", {4'd0, a}, 8'h0F);
    release_all();

    // en=1011 dir=1000: track3 drives b, b drives tracks 1 and 0.
    load_cfg(8'hB8);
    check_eq("b8_so", {7'd0, so}, 8'h01);
    a_drv = 4'b1000; a_oe = 4'b1000; #1;
    check_eq("b8_b_hi", {7'd0, b}, 8'h01);
    check_eq("b8_a_hi", {4'd0, a}, 8'h0F);
    a_drv = 4'b0000; #1;
    check_eq("b8_b_lo", {7'd0, b}, 8'h00);
    check_eq("b8_a_lo", {4'd0, a}, 8'h04);
    release_all();

    // Chain pass-through: the loaded byte drains out of so.
    chain_exp = 7'b0111000;
    for (int i = 0; i < 7; i++) begin
      shift_bit(1'b0);
      check_eq($sformatf("chain_edge%0d", 9 + i), {7'd0, so}, {7'd0, chain_exp[6-i]});
    end
    shift_bit(1'b0);
    check_eq("chain_edge16", {7'd0, so}, 8'h00);

    // Priority: all tracks request the pin, lowest index wins.
    load_cfg(8'hFF);
    a_drv = 4'b1010; a_oe = 4'b1111; #1;
    check_eq("prio_a0_lo", {7'd0, b}, 8'h00);
    a_drv = 4'b1011; #1;
    check_eq("prio_a0_hi", {7'd0, b}, 8'h01);
    release_all();

    // Pin to track: only track 2 closed, pointing at the track.
    load_cfg(8'h40);
    b_drv = 1'b1; b_oe = 1'b1; #1;
    check_eq("p2t_hi", {4'd0, a}, 8'h0F);
    b_drv = 1'b0; #1;
    check_eq("p2t_lo", {4'd0, a}, 8'h0B);
    release_all();

    // Clear, then reset after half of the 8'hB8 sequence.
    load_cfg(8'h00);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b1);
    rst_n = 1'b0; #1;
    check_eq("midrst_so", {7'd0, so}, 8'h00);
    a_drv = 4'b0000; a_oe = 4'b1111; #1;
    check_eq("midrst_b_open", {7'd0, b}, 8'h01);
    release_all();
    @(negedge clk); #1;
    rst_n = 1'b1;
    // Any surviving partial load would now appear on so.
    for (int i = 0; i < 8; i++) begin
      shift_bit(1'b0);
      check_eq($sformatf("midrst_drain%0d", i), {7'd0, so}, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
